// File: rtl/pc_fetch.sv
// Program counter and instruction fetch stage: two-state FETCH/HOLD sequencer
// that owns the PC, the fetched instruction register and next-PC selection.
module pc_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  pcsel,
  input  logic [31:0] jt,
  input  logic        irq,
  input  logic        done,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id,
  output logic        id_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_inc,
  output logic        irq_ok
);

  localparam logic [31:0] RESET_ADDR = 32'h8000_0000;
  localparam logic [31:0] ILLOP_ADDR = 32'h8000_0004;
  localparam logic [31:0] XADR_ADDR  = 32'h8000_0008;

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] id_reg, id_next;
  logic [31:0] npc;
  logic [30:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] jmp_target;

  // Offset is the word displacement scaled to bytes; the supervisor bit is
  // carried over untouched so a branch can never change privilege.
  assign pc_inc     = {pc_reg[31], pc_reg[30:0] + 31'd4};
  assign br_offset  = {{13{id_reg[15]}}, id_reg[15:0], 2'b00};
  assign br_target  = {pc_reg[31], pc_inc[30:0] + br_offset};
  assign jmp_target = {pc_reg[31] & jt[31], jt[30:2], 2'b00};

  always_comb begin
    npc = ILLOP_ADDR;
    case (pcsel)
      3'd0:    npc = pc_inc;
      3'd1:    npc = br_target;
      3'd2:    npc = jmp_target;
      3'd4:    npc = XADR_ADDR;
      default: npc = ILLOP_ADDR;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    id_next    = id_reg;
    case (state_reg)
      FETCH: begin
        if (imem_ack) begin
          id_next    = imem_rdata;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (done) begin
          pc_next    = npc;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_ADDR;
      id_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= {pc_next[31:2], 2'b00};
      id_reg    <= id_next;
    end
  end

  // Request is suppressed combinationally while reset is held.
  assign imem_req  = (state_reg == FETCH) && !reset;
  assign imem_addr = pc_reg;
  assign pc        = pc_reg;
  assign id        = id_reg;
  assign id_valid  = (state_reg == HOLD);
  assign irq_ok    = irq & ~pc_reg[31] & id_valid;

endmodule
